mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath. It generates the 3-bit ALUControl code consumed by the datapath ALU, plus every datapath write-enable and mux select.
- Moore FSM sequences fetch/decode/execute/memory/writeback. A combinational ALU decoder maps ALUOp and funct to ALUControl.
- Inputs are the instruction register fields and the ALU zero flag.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (fixed; exposed for bench forcing only)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag (y == 0)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = Data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs data
- alu_src_b  out  2  00 = rt data, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load = pc_write | (branch & zero)
- alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- instr_done  out  1  high in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Single clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- While rst_n is low:
  - state = S_FETCH.
  - mem_write, ir_write, reg_write, pc_en, instr_done and illegal_op are forced to 0 combinationally.
  - All other outputs take their S_FETCH values.
- Reset asserted mid-instruction aborts that instruction. The first rising edge after rst_n rises performs a full fetch.
- State encoding is 4-bit:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMRD = 3
  - MEMWB = 4
  - MEMWR = 5
  - EXECUTE = 6
  - ALUWB = 7
  - BRANCH = 8
  - ADDIEX = 9
  - ADDIWB = 10
  - JUMP = 11
- Encodings 12–15 are illegal and go to FETCH on the next edge.
- State transitions:
  - FETCH -> DECODE.
  - DECODE, by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op = 1 for that cycle
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
- Outputs per state. Unlisted signals are 0; alu_op defaults to 00.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: iord=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- pc_en is the only output that depends on a non-state input (zero). It is combinational, and in BRANCH it is valid in the same cycle as zero.
- ALU decoder (combinational, no latency):
  - alu_op 00 -> 010; alu_op 01 -> 110; alu_op 11 -> 010.
  - alu_op 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010. No flag is raised; the datapath still writes back.
- Cycles per instruction, FETCH through the final state:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal opcode 2
- instr_done is high in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - alu_op encodings
  - ALUControl codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), shared with the datapath ALU
- Sub-module mips_alu_decoder: alu_op[1:0] and funct[5:0] in, alu_control[2:0] out.
- The FSM (next-state logic, state register, output decode) stays in the top module.

Test Plan:
- Reset then release with opcode=100011 (lw): states go 0,1,2,3,4. reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done is high in cycle 5 only.
- opcode=000000, funct=101010 (SLT): alu_control=111 in EXECUTE and reg_dst=1 in ALUWB. Repeat with funct=100010: alu_control=110.
- beq (000100) with zero=1: pc_en=1 and pc_src=01 in BRANCH. With zero=0: pc_en=0. Next state is FETCH in both cases.
- opcode=111111: illegal_op pulses in DECODE and the next state is FETCH. No reg_write or mem_write is asserted at any point.
- rst_n driven low for 3 ns mid-MEMWR (sw): mem_write drops immediately and state=0. After release, FETCH asserts ir_write=1 and pc_en=1.
- Back-to-back j (000010) then addi (001000): 3 cycles then 4 cycles. alu_src_b=10 in ADDIEX; pc_src=10 and pc_en=1 in JUMP.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Holds FSM states, opcode/funct fields, ALUOp and ALUControl codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU decoder: maps alu_op and funct to the 3-bit ALUControl code.
// Ports: alu_op[1:0], funct[5:0] in; alu_control[2:0] out.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // unknown funct falls back to add
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// In: clk, rst_n, opcode, funct, zero. Out: datapath enables/selects.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state;
  state_t     state_n;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       done_s;
  logic       illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = S_FETCH;
    iord        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_s = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_op      = ALUOP_ADD;
    pc_write    = 1'b0;
    branch      = 1'b0;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    case (state)
      S_FETCH: begin
        state_n    = S_DECODE;
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_n = S_MEMADR;
          (opcode == OP_RTYPE): state_n = S_EXECUTE;
          (opcode == OP_BEQ):   state_n = S_BRANCH;
          (opcode == OP_ADDI):  state_n = S_ADDIEX;
          (opcode == OP_J):     state_n = S_JUMP;
          default: begin
            state_n   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_n   = (opcode == OP_SW) ? S_MEMWR
                                      : S_MEMRD;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        state_n = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_EXECUTE: begin
        state_n   = S_ALUWB;
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        done_s    = 1'b1;
      end
      S_ADDIEX: begin
        state_n   = S_ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done_s   = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // strobes are held off while reset is low
  assign mem_write  = rst_n & mem_write_s;
  assign ir_write   = rst_n & ir_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign instr_done = rst_n & done_s;
  assign illegal_op = rst_n & illegal_s;
  assign pc_en      = rst_n &
                      (pc_write | (branch & zero));
  assign state_dbg  = state;

  mips_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller.
// Directed and random instructions against a spec-level model.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  mips_multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;
  } ctl_t;

  function automatic ctl_t observed();
    ctl_t c;
    c = '{iord, mem_write, ir_write, reg_dst,
          mem_to_reg, reg_write, alu_src_a,
          alu_src_b, pc_src, pc_en, alu_control,
          instr_done, illegal_op, state_dbg};
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000,
                      6'b000100, 6'b001000, 6'b000010};
  endfunction

  // ALU operation an R-type funct selects
  function automatic logic [2:0] rtype_alu(
    input logic [5:0] fn);
    case (fn)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100010: return 3'b110;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // States visited by one instruction, fetch first
  function automatic void path(input logic [5:0] op,
                               output int q[$]);
    q = {0, 1};
    case (op)
      6'b100011: q = {q, 2, 3, 4};
      6'b101011: q = {q, 2, 5};
      6'b000000: q = {q, 6, 7};
      6'b000100: q = {q, 8};
      6'b001000: q = {q, 9, 10};
      6'b000010: q = {q, 11};
      default:   ;
    endcase
  endfunction

  // Expected outputs in a given state, from the state table
  function automatic ctl_t model(input int s,
    input logic [5:0] op, input logic [5:0] fn,
    input logic z);
    ctl_t e;
    e = '0;
    e.state = s[3:0];
    e.alu_control = 3'b010;
    case (s)
      0: begin
        e.alu_src_b = 2'b01; e.ir_write = 1;
        e.pc_en = 1;
      end
      1: begin
        e.alu_src_b = 2'b11;
        e.illegal_op = !legal(op);
      end
      2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3: e.iord = 1;
      4: begin e.mem_to_reg = 1; e.reg_write = 1; end
      5: begin e.iord = 1; e.mem_write = 1; end
      6: begin
        e.alu_src_a = 1; e.alu_control = rtype_alu(fn);
      end
      7: begin e.reg_dst = 1; e.reg_write = 1; end
      8: begin
        e.alu_src_a = 1; e.pc_src = 2'b01;
        e.alu_control = 3'b110; e.pc_en = z;
      end
      9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      10: e.reg_write = 1;
      11: begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    e.instr_done = s inside {4, 5, 7, 8, 10, 11};
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag,
    input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  // Runs one instruction; called just after a rising edge.
  // first=1 skips FETCH when it was already consumed.
  task automatic run(input logic [5:0] op,
    input logic [5:0] fn, input logic z, input int first);
    int q[$];
    opcode = op; funct = fn; zero = z;
    path(op, q);
    for (int i = first; i < q.size(); i++) begin
      @(negedge clk);
      check($sformatf("op%b s%0d", op, q[i]),
            model(q[i], op, fn, zero));
      if (q[i] == 8) begin
        zero = ~zero;
        #1;
        check("beq zero flip", model(8, op, fn, zero));
      end
      @(posedge clk);
      #1;
    end
  endtask

  ctl_t rst_exp;
  logic [5:0] ops[6];
  logic [5:0] fns[6];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000,
            6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010, 6'b111000};
    rst_n = 1'b0; opcode = 6'b100011;
    funct = '0; zero = 1'b0;
    rst_exp = model(0, opcode, funct, zero);
    rst_exp.ir_write = 0;
    rst_exp.pc_en = 0;
    #7;
    check("reset state", rst_exp);
    #1 rst_n = 1'b1;

    run(6'b100011, 6'b000000, 1'b0, 0);
    run(6'b000000, 6'b101010, 1'b0, 0);
    run(6'b000000, 6'b100010, 1'b1, 0);
    run(6'b000100, 6'b000000, 1'b1, 0);
    run(6'b000100, 6'b000000, 1'b0, 0);
    run(6'b111111, 6'b000000, 1'b0, 0);

    // sw aborted by a 3 ns reset pulse in MEMWR
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check("sw in memwr",
              model(5, opcode, funct, zero));
        rst_n = 1'b0;
        #1;
        rst_exp = model(0, opcode, funct, zero);
        rst_exp.ir_write = 0;
        rst_exp.pc_en = 0;
        check("abort memwr", rst_exp);
        #2 rst_n = 1'b1;
        #1;
        check("fetch after abort",
              model(0, opcode, funct, zero));
      end
      @(posedge clk);
      #1;
    end
    run(6'b101011, 6'b000000, 1'b0, 1);

    run(6'b000010, 6'b000000, 1'b0, 0);
    run(6'b001000, 6'b000000, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 6) == 6) ?
           6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ?
           6'($urandom) : fns[$urandom_range(0, 5)];
      run(op, fn, 1'($urandom), 0);
    end

    @(negedge clk);
    check_bit("idle fetch ir_write", ir_write, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
